// File: rtl/uart_pkg.sv
// rtl/uart_pkg.sv - shared state encoding, parity helper and configuration checks for the UART receiver
package uart_pkg;

  // Receive FSM states
  typedef enum logic [2:0] {
    IDLE,
    START,
    DATA,
    PARITY,
    STOP,
    WAIT_HIGH
  } rx_state_t;

  // Widest payload the receiver supports; the parity helper works on this width
  localparam int unsigned MAX_DATA_BITS = 9;

  // 1 when data bits plus the received parity bit disagree with the selected sense
  function automatic logic parity_err(input logic [MAX_DATA_BITS-1:0] data,
                                      input logic                     par_bit,
                                      input logic                     odd);
    return ((^data) ^ par_bit) != odd;
  endfunction

  // Configuration legality, evaluated at elaboration by the receiver top
  function automatic logic cfg_legal(input int clks_per_bit,
                                     input int data_bits,
                                     input int stop_bits);
    return (clks_per_bit >= 4) && (data_bits >= 5) && (data_bits <= 9) &&
           (stop_bits >= 1) && (stop_bits <= 2);
  endfunction

endpackage

// File: rtl/uart_rx_sync_vote.sv
// rtl/uart_rx_sync_vote.sv - two-flop synchroniser with a 3-tap majority vote on the RX line
module uart_rx_sync_vote (
  input  logic i_CLK,
  input  logic i_RST,
  input  logic i_Rx_Serial,
  output logic o_raw,
  output logic o_voted
);

  logic sync1_q, sync1_d;
  logic sync2_q, sync2_d;
  logic hist1_q, hist1_d;
  logic hist2_q, hist2_d;

  // Shift the line through the synchroniser and the vote history
  always_comb begin
    sync1_d = i_Rx_Serial;
    sync2_d = sync1_q;
    hist1_d = sync2_q;
    hist2_d = hist1_q;
  end

  // Everything resets to the idle (high) line level so no false start is seen
  always_ff @(posedge i_CLK or posedge i_RST) begin
    if (i_RST) begin
      sync1_q <= 1'b1;
      sync2_q <= 1'b1;
      hist1_q <= 1'b1;
      hist2_q <= 1'b1;
    end else begin
      sync1_q <= sync1_d;
      sync2_q <= sync2_d;
      hist1_q <= hist1_d;
      hist2_q <= hist2_d;
    end
  end

  assign o_raw   = sync2_q;
  assign o_voted = (sync2_q & hist1_q) | (sync2_q & hist2_q) | (hist1_q & hist2_q);

endmodule

// File: rtl/uart_rx_param.sv
// rtl/uart_rx_param.sv - parametrised UART receiver with error detection and a ready/valid holding register
module uart_rx_param import uart_pkg::*; #(
  parameter int CLKS_PER_BIT = 217,
  parameter int DATA_BITS    = 8,
  parameter int PARITY_EN    = 0,
  parameter int PARITY_ODD   = 0,
  parameter int STOP_BITS    = 1
) (
  input  logic                 i_CLK,
  input  logic                 i_RST,
  input  logic                 i_Rx_Serial,
  input  logic                 i_Rx_Ready,
  output logic                 o_Rx_DV,
  output logic [DATA_BITS-1:0] o_Rx_Byte,
  output logic                 o_Parity_Err,
  output logic                 o_Frame_Err,
  output logic                 o_Overrun,
  output logic                 o_Break,
  output logic                 o_Busy
);

  localparam int CNT_W = $clog2(CLKS_PER_BIT);
  localparam int IDX_W = $clog2(DATA_BITS + 1);
  localparam logic [CNT_W-1:0] HALF_CNT  = CNT_W'((CLKS_PER_BIT - 1) / 2);
  localparam logic [CNT_W-1:0] LAST_CNT  = CNT_W'(CLKS_PER_BIT - 1);
  localparam logic [IDX_W-1:0] LAST_DATA = IDX_W'(DATA_BITS - 1);
  localparam logic [IDX_W-1:0] LAST_STOP = IDX_W'(STOP_BITS - 1);

  if (!cfg_legal(CLKS_PER_BIT, DATA_BITS, STOP_BITS)) begin : g_bad_cfg
    $error("uart_rx_param: illegal CLKS_PER_BIT, DATA_BITS or STOP_BITS");
  end

  logic raw, voted;

  uart_rx_sync_vote u_sync_vote (
    .i_CLK      (i_CLK),
    .i_RST      (i_RST),
    .i_Rx_Serial(i_Rx_Serial),
    .o_raw      (raw),
    .o_voted    (voted)
  );

  rx_state_t            state_q, state_d;
  logic [CNT_W-1:0]     cnt_q, cnt_d;
  logic [IDX_W-1:0]     idx_q, idx_d;
  logic [DATA_BITS-1:0] shift_q, shift_d;
  logic                 perr_q, perr_d;
  logic                 ferr_q, ferr_d;
  logic                 zero_q, zero_d;
  logic                 bit_end, frame_done, frame_brk;

  logic                 dv_q, dv_d;
  logic [DATA_BITS-1:0] byte_q, byte_d;
  logic                 perr_out_q, perr_out_d;
  logic                 ferr_out_q, ferr_out_d;
  logic                 ovr_q, ovr_d;
  logic                 brk_q, brk_d;

  // Frame FSM: start validation, bit sampling, parity/stop checks and break tracking
  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    idx_d      = idx_q;
    shift_d    = shift_q;
    perr_d     = perr_q;
    ferr_d     = ferr_q;
    zero_d     = zero_q;
    frame_done = 1'b0;
    frame_brk  = 1'b0;
    bit_end    = (cnt_q == LAST_CNT);

    if (state_q inside {DATA, PARITY, STOP}) begin
      cnt_d = bit_end ? '0 : cnt_q + CNT_W'(1);
    end

    case (state_q)
      IDLE: begin
        cnt_d  = '0;
        idx_d  = '0;
        perr_d = 1'b0;
        ferr_d = 1'b0;
        zero_d = 1'b1;
        if (!raw) state_d = START;
      end
      START: begin
        if (cnt_q == HALF_CNT) begin
          cnt_d   = '0;
          state_d = voted ? IDLE : DATA;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      DATA: begin
        if (bit_end) begin
          shift_d = {voted, shift_q[DATA_BITS-1:1]};
          zero_d  = zero_q & ~voted;
          if (idx_q == LAST_DATA) begin
            idx_d   = '0;
            state_d = (PARITY_EN != 0) ? PARITY : STOP;
          end else begin
            idx_d = idx_q + IDX_W'(1);
          end
        end
      end
      PARITY: begin
        if (bit_end) begin
          perr_d  = parity_err(MAX_DATA_BITS'(shift_q), voted, (PARITY_ODD != 0));
          zero_d  = zero_q & ~voted;
          state_d = STOP;
        end
      end
      STOP: begin
        if (bit_end) begin
          ferr_d = ferr_q | ~voted;
          // Break only looks at the first stop bit
          if (idx_q == '0) zero_d = zero_q & ~voted;
          if (idx_q == LAST_STOP) begin
            frame_done = 1'b1;
            frame_brk  = zero_d;
            // A low line at frame end must go high again before a new start is trusted
            state_d    = (!voted || zero_d) ? WAIT_HIGH : IDLE;
          end else begin
            idx_d = idx_q + IDX_W'(1);
          end
        end
      end
      WAIT_HIGH: begin
        if (voted) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  // Frame FSM registers
  always_ff @(posedge i_CLK or posedge i_RST) begin
    if (i_RST) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      idx_q   <= '0;
      shift_q <= '0;
      perr_q  <= 1'b0;
      ferr_q  <= 1'b0;
      zero_q  <= 1'b1;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      idx_q   <= idx_d;
      shift_q <= shift_d;
      perr_q  <= perr_d;
      ferr_q  <= ferr_d;
      zero_q  <= zero_d;
    end
  end

  // Holding register: consume on handshake, load a finished frame or flag overrun/break
  always_comb begin
    dv_d       = dv_q;
    byte_d     = byte_q;
    perr_out_d = perr_out_q;
    ferr_out_d = ferr_out_q;
    ovr_d      = 1'b0;
    brk_d      = 1'b0;
    if (dv_q && i_Rx_Ready) dv_d = 1'b0;
    if (frame_done) begin
      if (frame_brk) begin
        brk_d = 1'b1;
      end else if (!dv_q || i_Rx_Ready) begin
        dv_d       = 1'b1;
        byte_d     = shift_q;
        perr_out_d = perr_q;
        ferr_out_d = ferr_d;
      end else begin
        ovr_d = 1'b1;
      end
    end
  end

  // Output registers
  always_ff @(posedge i_CLK or posedge i_RST) begin
    if (i_RST) begin
      dv_q       <= 1'b0;
      byte_q     <= '0;
      perr_out_q <= 1'b0;
      ferr_out_q <= 1'b0;
      ovr_q      <= 1'b0;
      brk_q      <= 1'b0;
    end else begin
      dv_q       <= dv_d;
      byte_q     <= byte_d;
      perr_out_q <= perr_out_d;
      ferr_out_q <= ferr_out_d;
      ovr_q      <= ovr_d;
      brk_q      <= brk_d;
    end
  end

  assign o_Rx_DV      = dv_q;
  assign o_Rx_Byte    = byte_q;
  assign o_Parity_Err = perr_out_q;
  assign o_Frame_Err  = ferr_out_q;
  assign o_Overrun    = ovr_q;
  assign o_Break      = brk_q;
  assign o_Busy       = (state_q != IDLE);

endmodule

// File: tb/tb_uart_rx_param.sv
// tb/tb_uart_rx_param.sv - scoreboard bench for the parametrised UART receiver (8N1 and 7E2 instances)
module tb_uart_rx_param;

  localparam int C    = 16;
  localparam int HALF = (C - 1) / 2;
  // Line drop to o_Rx_DV rise: 2 synchroniser cycles, then t0+1+HALF+9*C+1
  localparam int DV_LAT_8N1 = 2 + 1 + HALF + 9 * C + 1;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       rx8 = 1'b1, rdy8 = 1'b1, rx7 = 1'b1, rdy7 = 1'b1;
  logic       dv8, perr8, ferr8, ovr8, brk8, busy8;
  logic [7:0] byte8;
  logic       dv7, perr7, ferr7, ovr7, brk7, busy7;
  logic [6:0] byte7;

  always #5 clk = ~clk;

  uart_rx_param #(.CLKS_PER_BIT(C), .DATA_BITS(8), .PARITY_EN(0), .PARITY_ODD(0), .STOP_BITS(1)) u_dut8 (
    .i_CLK(clk), .i_RST(rst), .i_Rx_Serial(rx8), .i_Rx_Ready(rdy8),
    .o_Rx_DV(dv8), .o_Rx_Byte(byte8), .o_Parity_Err(perr8), .o_Frame_Err(ferr8),
    .o_Overrun(ovr8), .o_Break(brk8), .o_Busy(busy8)
  );

  uart_rx_param #(.CLKS_PER_BIT(C), .DATA_BITS(7), .PARITY_EN(1), .PARITY_ODD(0), .STOP_BITS(2)) u_dut7 (
    .i_CLK(clk), .i_RST(rst), .i_Rx_Serial(rx7), .i_Rx_Ready(rdy7),
    .o_Rx_DV(dv7), .o_Rx_Byte(byte7), .o_Parity_Err(perr7), .o_Frame_Err(ferr7),
    .o_Overrun(ovr7), .o_Break(brk7), .o_Busy(busy7)
  );

  int          checks = 0, failures = 0;
  int          cyc = 0;
  logic [10:0] q8[$], q7[$];
  int          ovr8_cnt = 0, brk8_cnt = 0, ovr7_cnt = 0, brk7_cnt = 0;
  int          rise8 = -1, drop8 = 0;
  logic        dv8_prev = 1'b0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  initial forever begin
    @(posedge clk);
    cyc++;
  end

  // Monitor: pops the scoreboard on every accepted word, tracks pulses and DV rise time
  initial begin
    logic [10:0] exp;
    forever begin
      @(negedge clk);
      if (!rst) begin
        if (dv8 && !dv8_prev) rise8 = cyc;
        if (ovr8) ovr8_cnt++;
        if (brk8) brk8_cnt++;
        if (ovr7) ovr7_cnt++;
        if (brk7) brk7_cnt++;
        if (dv8 && rdy8) begin
          if (q8.size() == 0) begin
            checks++; failures++;
            $display("FAIL dut8_unexpected_word: got 0x%0h expected none", byte8);
          end else begin
            exp = q8.pop_front();
            check("dut8_word", 32'({byte8, perr8, ferr8}), 32'(exp));
          end
        end
        if (dv7 && rdy7) begin
          if (q7.size() == 0) begin
            checks++; failures++;
            $display("FAIL dut7_unexpected_word: got 0x%0h expected none", byte7);
          end else begin
            exp = q7.pop_front();
            check("dut7_word", 32'({byte7, perr7, ferr7}), 32'(exp));
          end
        end
      end
      dv8_prev = dv8;
    end
  end

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic set_line(input int which, input logic v);
    if (which == 8) rx8 = v;
    else rx7 = v;
  endtask

  // Drives nbits bits LSB first; bit index 'glitch' gets a 1-cycle flip at its sample point
  task automatic send_line(input int which, input logic [15:0] bits, input int nbits, input int glitch);
    for (int i = 0; i < nbits; i++) begin
      if (i == 0 && which == 8) drop8 = cyc;
      set_line(which, bits[i]);
      if (i == glitch) begin
        tick(8);
        set_line(which, ~bits[i]);
        tick(1);
        set_line(which, bits[i]);
        tick(C - 9);
      end else begin
        tick(C);
      end
    end
  endtask

  function automatic logic [15:0] frame8(input logic [7:0] d, input logic stop);
    return {6'b111111, stop, d, 1'b0};
  endfunction

  function automatic logic [15:0] frame7(input logic [6:0] d, input logic par);
    return {5'b11111, 2'b11, par, d, 1'b0};
  endfunction

  task automatic drain(input string name);
    int n = 0;
    while ((q8.size() != 0 || q7.size() != 0) && n < 4 * C) begin
      tick(1);
      n++;
    end
    check(name, 32'(q8.size() + q7.size()), 0);
  endtask

  initial begin
    tick(5);
    check("reset_dut8", 32'({dv8, byte8, perr8, ferr8, ovr8, brk8, busy8}), 0);
    check("reset_dut7", 32'({dv7, byte7, perr7, ferr7, ovr7, brk7, busy7}), 0);
    rst = 1'b0;
    tick(5);

    // 8N1 0xA5 with latency check
    q8.push_back({1'b0, 8'hA5, 1'b0, 1'b0});
    send_line(8, frame8(8'hA5, 1'b1), 10, -1);
    tick(4);
    drain("t1_drain");
    check("t1_dv_latency", 32'(rise8 - drop8), DV_LAT_8N1);

    // 7E2 0x41: good parity, then bad parity
    q7.push_back({2'b0, 7'h41, 1'b0, 1'b0});
    send_line(7, frame7(7'h41, 1'b0), 11, -1);
    q7.push_back({2'b0, 7'h41, 1'b1, 1'b0});
    send_line(7, frame7(7'h41, 1'b1), 11, -1);
    tick(4);
    drain("t2_drain");

    // Overrun: second frame dropped while the first is held
    rdy8 = 1'b0;
    q8.push_back({1'b0, 8'h11, 1'b0, 1'b0});
    send_line(8, frame8(8'h11, 1'b1), 10, -1);
    send_line(8, frame8(8'h22, 1'b1), 10, -1);
    tick(4);
    check("t3_overrun_count", 32'(ovr8_cnt), 1);
    check("t3_held_dv", 32'(dv8), 1);
    check("t3_held_byte", 32'(byte8), 'h11);
    rdy8 = 1'b1;
    tick(1);
    check("t3_dv_fall", 32'(dv8), 0);
    drain("t3_drain");

    // Framing error: stop bit low for one bit time
    q8.push_back({1'b0, 8'h3C, 1'b0, 1'b1});
    send_line(8, frame8(8'h3C, 1'b0), 10, -1);
    set_line(8, 1'b1);
    tick(2 * C);
    drain("t4_drain");
    check("t4_idle_after_wait_high", 32'(busy8), 0);

    // Break: line low for 12 bit times
    set_line(8, 1'b0);
    tick(12 * C);
    check("t5_break_count", 32'(brk8_cnt), 1);
    check("t5_wait_high_busy", 32'(busy8), 1);
    check("t5_no_dv", 32'(dv8), 0);
    set_line(8, 1'b1);
    tick(C);
    check("t5_idle_after_release", 32'(busy8), 0);
    q8.push_back({1'b0, 8'h55, 1'b0, 1'b0});
    send_line(8, frame8(8'h55, 1'b1), 10, -1);
    tick(4);
    drain("t5_drain");

    // Short low glitch on an idle line
    set_line(8, 1'b0);
    tick(3);
    set_line(8, 1'b1);
    tick(2 * C);
    check("t6_glitch_idle", 32'({busy8, dv8}), 0);

    // 1-cycle glitch at the sample point of data bit 2
    q8.push_back({1'b0, 8'h5A, 1'b0, 1'b0});
    send_line(8, frame8(8'h5A, 1'b1), 10, 3);
    tick(4);
    drain("t6_vote_drain");

    // Reset mid-frame while a word is held
    rdy8 = 1'b0;
    send_line(8, frame8(8'hC3, 1'b1), 10, -1);
    tick(2);
    check("t6_held_before_reset", 32'(dv8), 1);
    send_line(8, frame8(8'h77, 1'b1), 4, -1);
    rst = 1'b1;
    set_line(8, 1'b1);
    tick(2);
    check("t6_reset_outputs", 32'({dv8, byte8, perr8, ferr8, ovr8, brk8, busy8}), 0);
    rst = 1'b0;
    rdy8 = 1'b1;
    tick(C);
    q8.push_back({1'b0, 8'h96, 1'b0, 1'b0});
    send_line(8, frame8(8'h96, 1'b1), 10, -1);
    tick(4);
    drain("t6_after_reset_drain");

    check("final_overrun_count", 32'(ovr8_cnt), 1);
    check("final_break_count", 32'(brk8_cnt), 1);
    check("final_dut7_pulses", 32'(ovr7_cnt + brk7_cnt), 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/uart_rx_param.md
Name: uart_rx_param

Overview:
Parametrised UART receiver, successor to the fixed 8N1 receiver. Supports configurable data width, optional even/odd parity and 1 or 2 stop bits. Adds 3-tap majority-vote sampling, framing/parity/overrun/break detection, and a ready/valid output holding register. Sits between the board RX pin and the command parser / packet controller.

Parameters:
CLKS_PER_BIT, 217, i_CLK cycles per bit (C); legal range >= 4
DATA_BITS, 8, payload bits per frame; legal range 5..9
PARITY_EN, 0, 1 = a parity bit follows the data
PARITY_ODD, 0, 1 = odd parity, 0 = even; ignored when PARITY_EN=0
STOP_BITS, 1, number of stop bits; 1 or 2

Ports:
i_CLK  in  1  clock
i_RST  in  1  asynchronous, active-high reset
i_Rx_Serial  in  1  asynchronous serial line; idles high
i_Rx_Ready  in  1  consumer accepts the held word this cycle
o_Rx_DV  out  1  held word valid; stays high until accepted
o_Rx_Byte  out  DATA_BITS  received payload, LSB first on the line
o_Parity_Err  out  1  qualifies the held word: parity mismatch
o_Frame_Err  out  1  qualifies the held word: a stop bit sampled 0
o_Overrun  out  1  1-cycle pulse: a frame completed while the register was full; the new frame is dropped
o_Break  out  1  1-cycle pulse: break condition detected
o_Busy  out  1  FSM not in IDLE

Behaviour:
- Reset: all outputs 0. Synchroniser flops and vote history reset to 1. FSM in IDLE, counters 0.
- Input path: 2-flop synchroniser, then a 3-deep history of synced values. Voted bit = majority of the current synced value and the 2 previous ones.
- Clock counter: $clog2(CLKS_PER_BIT) bits wide. HALF = (CLKS_PER_BIT-1)/2, integer division.
- IDLE: counters cleared. Raw synced value 0 at cycle t0 -> START.
- START: counter increments. At count==HALF, sample the voted bit.
  - Sample 0 -> DATA with counter 0.
  - Sample 1 -> IDLE (glitch). No flags.
- Sample timing: sample n occurs at cycle t0+1+HALF+n*C, where n=0 is the start bit.
- DATA: at count==C-1, sample the voted bit into bit index k (LSB first), counter -> 0.
  - After DATA_BITS samples -> PARITY if PARITY_EN, else STOP.
- PARITY: one sample. Parity error = (XOR of data ^ parity bit) != PARITY_ODD.
- STOP: STOP_BITS samples. Any stop sample of 0 sets the frame error.
  - The last stop sample ends the frame. There is no wait for bit end: the FSM returns to IDLE on the next cycle so it can resynchronise.
  - Exception: if the last stop sample is 0, go to WAIT_HIGH.
- WAIT_HIGH: stay until the voted line is 1, then -> IDLE. Prevents a false start while the line is held low.
- Break: all data bits 0, parity bit 0 (if enabled) and first stop bit 0.
  - o_Break pulses the cycle after the last sample.
  - No word is delivered and no overrun is raised; the FSM enters WAIT_HIGH.
- Frame completion (non-break): in the cycle after the last stop sample, one of the following applies.
  - Register empty, or o_Rx_DV && i_Rx_Ready this cycle: load o_Rx_Byte, o_Parity_Err and o_Frame_Err; o_Rx_DV=1.
  - Otherwise: o_Overrun=1 for 1 cycle; the held word and its flags are unchanged.
- Handshake: o_Rx_DV && i_Rx_Ready consumes the word. o_Rx_DV falls the next cycle unless a new word loads in the same cycle.
  - o_Rx_Byte and the error flags are stable while o_Rx_DV=1.
- Reset mid-frame: immediate return to the reset state. The partial frame is discarded.

Decomposition:
- Package uart_pkg holds:
  - state encoding: IDLE, START, DATA, PARITY, STOP, WAIT_HIGH
  - parity function
  - parameter legality checks (elaboration-time assertions on CLKS_PER_BIT, DATA_BITS, STOP_BITS)
- Sub-module uart_rx_sync_vote: 2-flop synchroniser plus 3-tap majority vote. Outputs the raw synced value and the voted bit.

Test Plan:
1. Bench parameters: C=16, 8N1. Send 0xA5, i_Rx_Ready=1. Expect o_Rx_DV pulse with o_Rx_Byte=0xA5, both error flags 0, and the DV rise cycle = t0+1+7+9*16+1.
2. 7E2 (DATA_BITS=7, PARITY_EN=1, PARITY_ODD=0, STOP_BITS=2). Send 0x41 with the correct parity bit 0 -> 0x41, no errors. Then send 0x41 with parity bit 1 -> 0x41, o_Parity_Err=1.
3. 8N1, i_Rx_Ready=0. Send 0x11 then 0x22 -> 0x11 held, o_Overrun pulses once. Raise ready -> 0x11 consumed, o_Rx_DV falls.
4. 8N1. Send 0x3C with the stop bit driven 0 for one bit time, then the line high -> 0x3C delivered, o_Frame_Err=1.
5. Hold the line low for 12 bit times -> one o_Break pulse, no o_Rx_DV, FSM in WAIT_HIGH. Release the line, then send 0x55 -> 0x55 received cleanly.
6. Two noise cases, then a reset:
   - 3-cycle low glitch on an idle line -> return to IDLE, no outputs.
   - 1-cycle glitch inside a data bit at a sample point -> correct byte, thanks to the vote.
   - i_RST asserted mid-frame -> all outputs 0; the next full frame is received correctly.
